// File: rtl/onehot_encoder_filt.sv
// One-hot to binary encoder with a stability filter, strict or priority decode,
// valid/ready output handshake and a sticky strict-mode fault flag.
//
//   state     | meaning
//   ----------+------------------------------------------------------------
//   S_IDLE    | waiting for a non-zero input while enabled
//   S_FILTER  | candidate captured, counting consecutive equal samples
//   S_PRESENT | code presented, waiting for out_ready
//   S_HOLD    | pattern consumed or faulted, waiting for the input to change
module onehot_encoder_filt #(
  parameter int WIDTH         = 16,
  parameter int OUT_W         = $clog2(WIDTH),
  parameter int STABLE_CYCLES = 2,
  parameter int PRIORITY_MODE = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [WIDTH-1:0] encoder_in,
  output logic [OUT_W-1:0] binary_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             error,
  input  logic             err_clr,
  output logic             busy
);

  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_FILTER, S_PRESENT, S_HOLD} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   in_q, in_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [OUT_W-1:0]   code_q, code_d;
  logic               valid_q, valid_d;
  logic               error_q, error_d;

  logic [OUT_W-1:0]   hi_idx;
  logic               seen;
  logic               multi;
  logic               fault;

  // Highest set index serves both modes; in strict mode it is only used when
  // exactly one bit is set.
  always_comb begin
    hi_idx = '0;
    seen   = 1'b0;
    multi  = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (in_q[i]) begin
        if (seen) multi = 1'b1;
        seen   = 1'b1;
        hi_idx = OUT_W'(i);
      end
    end
  end

  assign fault = (PRIORITY_MODE == 0) && multi;

  always_comb begin
    state_d = state_q;
    in_d    = in_q;
    cnt_d   = cnt_q;
    code_d  = code_q;
    valid_d = valid_q;
    error_d = error_q;
    if (err_clr) error_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (enable && (encoder_in != '0)) begin
          in_d    = encoder_in;
          cnt_d   = CNT_W'(1);
          state_d = S_FILTER;
        end
      end
      S_FILTER: begin
        if (!enable || (encoder_in == '0)) begin
          state_d = S_IDLE;
        end else if (encoder_in != in_q) begin
          in_d  = encoder_in;
          cnt_d = CNT_W'(1);
        end else if (cnt_q < CNT_MAX) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else if (fault) begin
          error_d = 1'b1;
          state_d = S_HOLD;
        end else begin
          code_d  = hi_idx;
          valid_d = 1'b1;
          state_d = S_PRESENT;
        end
      end
      S_PRESENT: begin
        if (out_ready) begin
          valid_d = 1'b0;
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (encoder_in != in_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      in_q    <= '0;
      cnt_q   <= '0;
      code_q  <= '0;
      valid_q <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      in_q    <= in_d;
      cnt_q   <= cnt_d;
      code_q  <= code_d;
      valid_q <= valid_d;
      error_q <= error_d;
    end
  end

  assign binary_out = code_q;
  assign out_valid  = valid_q;
  assign error      = error_q;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_onehot_encoder_filt.sv
// Bench for onehot_encoder_filt: a strict and a priority instance share stimulus;
// expected codes are queued at stimulus time and popped by per-instance monitors.
module tb_onehot_encoder_filt;
  localparam int W  = 16;
  localparam int OW = 4;
  localparam int S  = 2;

  logic          clk = 1'b0;
  logic          rst_n, enable, out_ready, err_clr;
  logic [W-1:0]  encoder_in;
  logic [OW-1:0] binary_out, binary_out_p;
  logic          out_valid, error, busy;
  logic          out_valid_p, error_p, busy_p;
  logic          ready_p;

  int checks   = 0;
  int failures = 0;
  int q_s[$];
  int q_p[$];
  int ready_mode = 2;   // 0 random, 1 held low, 2 held high

  assign ready_p = 1'b1;
  always #5 clk = ~clk;

  onehot_encoder_filt #(.WIDTH(W), .STABLE_CYCLES(S), .PRIORITY_MODE(0)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .encoder_in(encoder_in),
    .binary_out(binary_out), .out_valid(out_valid), .out_ready(out_ready),
    .error(error), .err_clr(err_clr), .busy(busy));

  onehot_encoder_filt #(.WIDTH(W), .STABLE_CYCLES(S), .PRIORITY_MODE(1)) dut_p (
    .clk(clk), .rst_n(rst_n), .enable(enable), .encoder_in(encoder_in),
    .binary_out(binary_out_p), .out_valid(out_valid_p), .out_ready(ready_p),
    .error(error_p), .err_clr(err_clr), .busy(busy_p));

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Code of the highest set bit: floor(log2(p)).
  function automatic int code_of(input logic [W-1:0] p);
    return $clog2(int'(p) + 1) - 1;
  endfunction

  function automatic logic [W-1:0] rand_onehot();
    logic [W-1:0] v;
    v = '0;
    v[$urandom_range(0, W-1)] = 1'b1;
    return v;
  endfunction

  function automatic logic [W-1:0] rand_multi();
    logic [W-1:0] v;
    int a, b;
    a = $urandom_range(0, W-1);
    b = $urandom_range(0, W-1);
    while (b == a) b = $urandom_range(0, W-1);
    v = '0;
    v[a] = 1'b1;
    v[b] = 1'b1;
    return v;
  endfunction

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic zeros(input int n);
    encoder_in = '0;
    step(n);
  endtask

  task automatic expect_pat(input logic [W-1:0] p);
    if ($countones(p) == 1) q_s.push_back(code_of(p));
    q_p.push_back(code_of(p));
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((q_s.size() != 0 || q_p.size() != 0) && n < 400) begin
      step(1);
      n++;
    end
    chk("drain_pending", q_s.size() + q_p.size(), 0);
    q_s.delete();
    q_p.delete();
    step(1);
  endtask

  task automatic err_check();
    chk("strict_error_set", error, 1);
    chk("priority_error", error_p, 0);
    err_clr = 1'b1;
    step(1);
    err_clr = 1'b0;
    chk("strict_error_clr", error, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_binary_out"}, binary_out, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_error"}, error, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_busy_p"}, busy_p, 0);
  endtask

  task automatic rand_event();
    int kind, h;
    logic [W-1:0] p, g;
    kind = $urandom_range(0, 9);
    zeros(3);
    p = ($urandom_range(0, 3) == 0) ? rand_multi() : rand_onehot();
    if (kind <= 5) begin
      h = S + 1 + $urandom_range(0, 4);
      expect_pat(p);
      encoder_in = p;
      step(h);
      if ($countones(p) > 1) err_check();
    end else if (kind <= 7) begin
      g = rand_onehot();
      while (g == p) g = rand_onehot();
      encoder_in = g;
      step($urandom_range(1, S));
      expect_pat(p);
      encoder_in = p;
      step(S + 1 + $urandom_range(0, 3));
      if ($countones(p) > 1) err_check();
    end else if (kind == 8) begin
      encoder_in = p;
      step($urandom_range(1, S));
      encoder_in = '0;
    end else begin
      enable = 1'b0;
      encoder_in = p;
      repeat (S + 3) begin
        step(1);
        chk("en_low_busy", busy, 0);
        chk("en_low_busy_p", busy_p, 0);
      end
      encoder_in = '0;
      step(1);
      enable = 1'b1;
    end
    wait_drain();
  endtask

  // Strict instance monitor: also drives out_ready.
  initial begin
    bit pend;
    bit r;
    int last;
    pend = 1'b0;
    last = 0;
    out_ready = 1'b1;
    forever begin
      @(negedge clk);
      #1;
      if (!rst_n) begin
        last = 0;
        pend = 1'b0;
      end else begin
        r = (ready_mode == 2) || (ready_mode == 0 && $urandom_range(0, 99) < 55);
        out_ready = r;
        if (pend) chk("stall_valid_held", out_valid, 1);
        if (out_valid) begin
          if (q_s.size() == 0) begin
            chk("unexpected_valid", out_valid, 0);
            pend = 1'b0;
          end else begin
            chk("code", binary_out, q_s[0]);
            if (r) begin
              last = q_s.pop_front();
              pend = 1'b0;
            end else begin
              pend = 1'b1;
            end
          end
        end else begin
          pend = 1'b0;
          chk("code_held", binary_out, last);
        end
      end
    end
  end

  // Priority instance monitor: always ready, never errors.
  initial begin
    int last;
    last = 0;
    forever begin
      @(negedge clk);
      #1;
      if (!rst_n) begin
        last = 0;
      end else begin
        chk("p_error_low", error_p, 0);
        if (out_valid_p) begin
          if (q_p.size() == 0) begin
            chk("p_unexpected_valid", out_valid_p, 0);
          end else begin
            chk("p_code", binary_out_p, q_p[0]);
            last = q_p.pop_front();
          end
        end else begin
          chk("p_code_held", binary_out_p, last);
        end
      end
    end
  end

  initial begin
    int n;
    rst_n = 1'b1;
    enable = 1'b1;
    err_clr = 1'b0;
    encoder_in = '0;
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("rst_async");
    step(2);
    rst_n = 1'b1;
    repeat (4) begin
      step(1);
      chk("idle_busy", busy, 0);
    end

    // Basic accept and latency
    expect_pat(16'h0040);
    encoder_in = 16'h0040;
    step(1); chk("lat_edge0", out_valid, 0);
    step(1); chk("lat_edge1", out_valid, 0);
    step(1); chk("lat_edge2", out_valid, 1);
    chk("basic_code", binary_out, 6);
    step(1); chk("one_cycle_valid", out_valid, 0);
    step(6); chk("code_kept", binary_out, 6);
    wait_drain();

    // Glitch filter
    zeros(3);
    encoder_in = 16'h0040;
    step(2);
    expect_pat(16'h8000);
    encoder_in = 16'h8000;
    step(2); chk("glitch_not_yet", out_valid, 0);
    step(1); chk("glitch_valid", out_valid, 1);
    chk("glitch_code", binary_out, 15);
    step(3);
    wait_drain();

    // Strict fault, clear, then set-wins-over-clear
    zeros(3);
    expect_pat(16'h0050);
    encoder_in = 16'h0050;
    step(S + 1);
    chk("fault_no_valid", out_valid, 0);
    chk("fault_code_kept", binary_out, 15);
    err_check();
    zeros(3);
    expect_pat(16'h0050);
    encoder_in = 16'h0050;
    step(S);
    err_clr = 1'b1;
    step(1);
    err_clr = 1'b0;
    chk("set_wins", error, 1);
    wait_drain();

    // Asynchronous reset mid-clock in HOLD with error set
    #2 rst_n = 1'b0;
    encoder_in = '0;
    #1 check_reset_outputs("rst_hold");
    step(2);
    rst_n = 1'b1;
    repeat (3) begin
      step(1);
      chk("post_rst_busy", busy, 0);
    end

    // Bit 0 is a valid event
    expect_pat(16'h0001);
    encoder_in = 16'h0001;
    step(S + 1);
    chk("bit0_valid", out_valid, 1);
    chk("bit0_code", binary_out, 0);
    step(2);
    wait_drain();

    // Backpressure with input change during the stall
    zeros(3);
    ready_mode = 1;
    expect_pat(16'h0040);
    expect_pat(16'h0004);
    encoder_in = 16'h0040;
    n = 0;
    while (!out_valid && n < 20) begin
      step(1);
      n++;
    end
    chk("stall_start", out_valid, 1);
    for (int i = 0; i < 5; i++) begin
      step(1);
      if (i == 1) encoder_in = 16'h0004;
      chk("stall_valid", out_valid, 1);
      chk("stall_code", binary_out, 6);
    end
    ready_mode = 2;
    wait_drain();
    chk("rearm_code", binary_out, 2);

    // Enable low blocks capture
    zeros(3);
    enable = 1'b0;
    encoder_in = 16'h0100;
    repeat (6) begin
      step(1);
      chk("en_busy", busy, 0);
      chk("en_valid", out_valid, 0);
    end
    encoder_in = '0;
    step(1);
    enable = 1'b1;

    // Reset one edge after capture
    zeros(3);
    encoder_in = 16'h0020;
    step(1);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("rst_filter");
    step(2);
    expect_pat(16'h0020);
    rst_n = 1'b1;
    step(S + 3);
    wait_drain();
    chk("after_rst_code", binary_out, 5);

    // Randomised events with random backpressure
    ready_mode = 0;
    repeat (60) rand_event();
    ready_mode = 2;
    zeros(3);
    wait_drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/onehot_encoder_filt.md
# onehot_encoder_filt

Parametrised, clocked one-hot to binary encoder for control-path inputs such as encoder wheels, status buses and selector strobes. The input is filtered for stability, decoded in strict one-hot or highest-bit-priority mode, and presented as a binary code over a valid/ready handshake. The last accepted code is held between events. Strict-mode encoding faults raise a sticky error flag.

## Interface
Parameters:
- `WIDTH`, default 16: one-hot input width, range 2..256.
- `OUT_W`, default `$clog2(WIDTH)`: code width. Derived; never overridden.
- `STABLE_CYCLES`, default 2: consecutive equal samples required after capture, range 1..255.
- `PRIORITY_MODE`, default 0:
  - 0 = strict one-hot; more than one bit set is an error.
  - 1 = the highest set index wins; no error is possible.

Ports:
- `clk`, input, 1: the single clock. All logic is on the rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `enable`, input, 1: allows capture of new input events.
- `encoder_in`, input, WIDTH: raw one-hot input.
- `binary_out`, output, OUT_W: last accepted code.
- `out_valid`, output, 1: `binary_out` holds a new, unconsumed code.
- `out_ready`, input, 1: consumer accepts the code.
- `error`, output, 1: sticky strict-mode fault.
- `err_clr`, input, 1: synchronous clear of `error`.
- `busy`, output, 1: high when the FSM is not in IDLE.

## Operation
- Internal state:
  - `in_q`, WIDTH bits: captured candidate.
  - `cnt`, `$clog2(STABLE_CYCLES+1)` bits: stability count.
  - FSM with states IDLE, FILTER, PRESENT, HOLD.
- An all-zero `encoder_in` is "no event". It is never captured and never flagged.
- Bit i set decodes to code i. Bit 0 gives code 0, which is a valid event.
- **IDLE**
  - If `enable` is high and `encoder_in` is non-zero: `in_q <= encoder_in`, `cnt <= 1`, go to FILTER.
- **FILTER**
  - If `enable` is low: go to IDLE.
  - Else if `encoder_in == 0`: go to IDLE.
  - Else if `encoder_in != in_q`: recapture (`in_q <= encoder_in`, `cnt <= 1`) and stay in FILTER.
  - Else if `cnt < STABLE_CYCLES`: `cnt++`.
  - Else decide:
    - Valid: `binary_out <= code`, `out_valid <= 1`, go to PRESENT.
    - Strict mode with popcount(`in_q`) > 1: `error <= 1`, go to HOLD. `binary_out` is unchanged and `out_valid` stays low.
- **PRESENT**
  - `out_valid` is high. `binary_out` is frozen.
  - `enable` and `encoder_in` are ignored.
  - On an edge with `out_ready` high: `out_valid <= 0`, go to HOLD.
- **HOLD**
  - Wait until `encoder_in != in_q`, then go to IDLE.
  - This is a re-arm: the same pattern is never reported twice without a change.
  - `enable` has no effect in HOLD.
- `binary_out` keeps the last accepted code indefinitely. It changes only at a FILTER decide edge.
- **Error flag**
  - `err_clr` clears `error` on the next edge.
  - If set and clear happen on the same edge, set wins.
- `busy` is high in FILTER, PRESENT and HOLD.

## Timing
- **Reset** (asynchronous, taking effect immediately on `rst_n` low):
  - FSM = IDLE, `in_q` = 0, `cnt` = 0.
  - `binary_out` = 0, `out_valid` = 0, `error` = 0, `busy` = 0.
- **Latency**
  - Edge 0 captures the input. The decide happens at edge STABLE_CYCLES.
  - `out_valid` is high after edge STABLE_CYCLES.
  - The input must be equal at edges 0..STABLE_CYCLES, i.e. STABLE_CYCLES+1 sampled edges.
- **Handshake**
  - A transfer occurs on any edge where `out_valid` and `out_ready` are both high. `out_valid` is low after that edge.
  - If `out_ready` is held high, `out_valid` is high for exactly one cycle.
  - `out_ready` while `out_valid` is low is ignored.
- **Minimum event-to-event period** (with `out_ready` high): STABLE_CYCLES+1 edges, plus 1 PRESENT edge, plus 1 HOLD edge, plus 1 IDLE edge.
- A change on `encoder_in` during FILTER restarts the count. There is no partial credit.
- Reset asserted in any state aborts the operation. The pending code is lost and not presented.

## Test plan
1. **Reset.** Assert `rst_n` low mid-clock with no edge. Required: all outputs 0 immediately. After release with `encoder_in` = 0: `busy` stays 0.
2. **Basic accept.** WIDTH=16, strict, STABLE_CYCLES=2, `out_ready`=1. Hold `encoder_in` = 16'h0040. Required: `out_valid`=1 for one cycle after edge 2 with `binary_out`=6. `binary_out` stays 6 afterwards. No second report until the input changes.
3. **Glitch filter.** Apply 16'h0040 for 2 edges, then hold 16'h8000. Required: 6 is never reported; `binary_out`=15 exactly 2 edges after the first 16'h8000 capture edge. Separately, 16'h0001 must yield code 0 with `out_valid`=1.
4. **Strict error vs priority.** Apply 16'h0050.
   - Strict mode: `error`=1, `out_valid` never rises, `binary_out` is unchanged. Pulse `err_clr` and the error clears. `err_clr` on the same edge as a new fault leaves `error`=1.
   - PRIORITY_MODE=1: code 6 is reported with `error`=0.
5. **Backpressure and enable.** Hold `out_ready`=0 for 5 cycles after `out_valid` rises, and change `encoder_in` to 16'h0004 meanwhile. Required: `out_valid` and `binary_out` stay stable through the stall. Raising `out_ready` completes a single transfer. The FSM then leaves HOLD on the changed input and reports 2. With `enable` low, a new input is never captured and `busy` stays 0.
6. **Reset mid-FILTER.** Assert `rst_n` low one edge after capture. Required: no code is presented and all outputs read 0. After release, the same input held stable is accepted normally.
